// File: rtl/sift_match_engine.sv
// sift_match_engine
//
// Descriptor matcher for the SIFT matching stage. A group of LANES image
// descriptors is loaded, then every target descriptor group is streamed out
// of target memory. For each image lane the best and second-best SAD
// distances are tracked. After the scan, a Lowe ratio test is applied and
// one result per valid image keypoint is emitted on a ready/valid stream.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin a run (sampled in IDLE only)
//   img_kpt_num        image keypoint count, latched on start
//   tar_kpt_num        target keypoint count, latched on start
//   desc_req           requesting the next image group (high throughout REQ)
//   desc_valid         img_desc carries the requested group this cycle
//   img_desc           image group, lane k at [k*DESC_W +: DESC_W]
//   tar_rd_en          target memory read enable
//   tar_addr           target group address (data returns one cycle later)
//   tar_desc           target group read data
//   res_valid/ready    result handshake
//   res_img_idx        image keypoint index
//   res_tar_idx        index of the best target keypoint
//   res_best           best SAD distance
//   res_second         second-best SAD distance
//   res_accept         ratio test passed
//   busy               high whenever not IDLE
//   done               one-cycle pulse at the end of a run
module sift_match_engine #(
    parameter int LANES     = 4,
    parameter int DESC_W    = 384,
    parameter int ELEM_W    = 8,
    parameter int ADDR_W    = 9,
    parameter int IDX_W     = 11,
    parameter int DIST_W    = 16,
    parameter int RATIO_NUM = 3,
    parameter int RATIO_SH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [IDX_W-1:0]          img_kpt_num,
    input  logic [IDX_W-1:0]          tar_kpt_num,
    output logic                      desc_req,
    input  logic                      desc_valid,
    input  logic [LANES*DESC_W-1:0]   img_desc,
    output logic                      tar_rd_en,
    output logic [ADDR_W-1:0]         tar_addr,
    input  logic [LANES*DESC_W-1:0]   tar_desc,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IDX_W-1:0]          res_img_idx,
    output logic [IDX_W-1:0]          res_tar_idx,
    output logic [DIST_W-1:0]         res_best,
    output logic [DIST_W-1:0]         res_second,
    output logic                      res_accept,
    output logic                      busy,
    output logic                      done
);

    localparam int NELEM = DESC_W / ELEM_W;
    localparam int KW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW    = DIST_W + RATIO_SH + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SCAN, S_DRAIN, S_EMIT, S_DONE
    } state_t;

    // Sum of absolute element differences; elements are unsigned, so the
    // difference is formed as a signed value one bit wider.
    function automatic logic [DIST_W-1:0] sad(input logic [DESC_W-1:0] a,
                                              input logic [DESC_W-1:0] b);
        logic [DIST_W-1:0]        acc;
        logic signed [ELEM_W:0]   diff;
        logic signed [ELEM_W:0]   mag;
        acc = '0;
        for (int e = 0; e < NELEM; e++) begin
            diff = $signed({1'b0, a[e*ELEM_W +: ELEM_W]}) - $signed({1'b0, b[e*ELEM_W +: ELEM_W]});
            mag  = (diff < 0) ? -diff : diff;
            acc  = acc + DIST_W'($unsigned(mag));
        end
        return acc;
    endfunction

    // Lowe ratio test: best / second < RATIO_NUM / 2^RATIO_SH.
    function automatic logic ratio_pass(input logic [DIST_W-1:0] b,
                                        input logic [DIST_W-1:0] s);
        logic [RW-1:0] lhs;
        logic [RW-1:0] rhs;
        lhs = RW'(b) << RATIO_SH;
        rhs = RW'(s) * RW'(RATIO_NUM);
        return lhs < rhs;
    endfunction

    state_t             state;
    logic [IDX_W-1:0]   img_num;
    logic [IDX_W-1:0]   tar_num;
    logic [IDX_W-1:0]   img_grps;
    logic [IDX_W-1:0]   grp;
    logic [ADDR_W-1:0]  tar_last;
    logic [ADDR_W-1:0]  scan_addr;
    logic [1:0]         drain_cnt;
    logic [KW-1:0]      emit_k;
    logic               res_valid_q;

    logic [DESC_W-1:0]  img_reg  [LANES];
    logic [DIST_W-1:0]  best     [LANES];
    logic [DIST_W-1:0]  second   [LANES];
    logic [IDX_W-1:0]   best_idx [LANES];

    logic [IDX_W-1:0]   img_grps_c;
    logic [ADDR_W-1:0]  tar_last_c;
    logic               next_lane_ok;
    logic               next_grp_ok;
    logic               trk_load;

    assign img_grps_c   = IDX_W'((32'(img_kpt_num) + 32'(LANES) - 32'd1) / 32'(LANES));
    assign tar_last_c   = ADDR_W'((32'(tar_kpt_num) + 32'(LANES) - 32'd1) / 32'(LANES) - 32'd1);
    assign next_lane_ok = (32'(emit_k) + 32'd1 < 32'(LANES)) &&
                          (32'(grp) * 32'(LANES) + 32'(emit_k) + 32'd1 < 32'(img_num));
    assign next_grp_ok  = (32'(grp) + 32'd1) < 32'(img_grps);
    assign trk_load     = (state == S_REQ) && desc_valid;

    // Control FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            img_num     <= '0;
            tar_num     <= '0;
            img_grps    <= '0;
            grp         <= '0;
            tar_last    <= '0;
            scan_addr   <= '0;
            drain_cnt   <= '0;
            emit_k      <= '0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        img_num  <= img_kpt_num;
                        tar_num  <= tar_kpt_num;
                        img_grps <= img_grps_c;
                        tar_last <= tar_last_c;
                        grp      <= '0;
                        state    <= (img_kpt_num != '0 && tar_kpt_num != '0) ? S_REQ : S_DONE;
                    end
                end
                S_REQ: begin
                    if (desc_valid) begin
                        scan_addr <= '0;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_addr == tar_last) begin
                        scan_addr <= '0;
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        scan_addr <= scan_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Three cycles lets the last group pass all three stages.
                    if (drain_cnt == 2'd2) begin
                        emit_k      <= '0;
                        res_valid_q <= 1'b1;
                        state       <= S_EMIT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        if (next_lane_ok) begin
                            emit_k <= emit_k + 1'b1;
                        end else begin
                            emit_k      <= '0;
                            res_valid_q <= 1'b0;
                            if (next_grp_ok) begin
                                grp   <= grp + 1'b1;
                                state <= S_REQ;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign desc_req  = (state == S_REQ);
    assign tar_rd_en = (state == S_SCAN);
    assign tar_addr  = scan_addr;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) img_reg[k] <= '0;
        end else if (trk_load) begin
            for (int k = 0; k < LANES; k++) img_reg[k] <= img_desc[k*DESC_W +: DESC_W];
        end
    end

    // ---- stage p0: address issued, memory read in flight ----
    logic               vld_p0;
    logic [IDX_W-1:0]   base_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            base_p0 <= '0;
        end else begin
            vld_p0  <= tar_rd_en;
            base_p0 <= IDX_W'(32'(scan_addr) * 32'(LANES));
        end
    end

    // ---- stage p1: target data and lane-valid mask registered ----
    logic               vld_p1;
    logic [LANES-1:0]   mask_p1;
    logic [IDX_W-1:0]   base_p1;
    logic [DESC_W-1:0]  tar_p1 [LANES];
    logic [LANES-1:0]   mask_c;

    always_comb begin
        mask_c = '0;
        for (int j = 0; j < LANES; j++)
            mask_c[j] = vld_p0 && ((32'(base_p0) + 32'(j)) < 32'(tar_num));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            mask_p1 <= '0;
            base_p1 <= '0;
            for (int j = 0; j < LANES; j++) tar_p1[j] <= '0;
        end else begin
            vld_p1  <= vld_p0;
            mask_p1 <= mask_c;
            base_p1 <= base_p0;
            for (int j = 0; j < LANES; j++) tar_p1[j] <= tar_desc[j*DESC_W +: DESC_W];
        end
    end

    // ---- stage p2: LANES x LANES SAD matrix registered ----
    logic               vld_p2;
    logic [LANES-1:0]   mask_p2;
    logic [IDX_W-1:0]   base_p2;
    logic [DIST_W-1:0]  sad_p2 [LANES][LANES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            mask_p2 <= '0;
            base_p2 <= '0;
            for (int i = 0; i < LANES; i++)
                for (int j = 0; j < LANES; j++) sad_p2[i][j] <= '0;
        end else begin
            vld_p2  <= vld_p1;
            mask_p2 <= mask_p1;
            base_p2 <= base_p1;
            for (int i = 0; i < LANES; i++)
                for (int j = 0; j < LANES; j++) sad_p2[i][j] <= sad(img_reg[i], tar_p1[j]);
        end
    end

    // ---- stage p3: best / second-best trackers ----
    logic [DIST_W-1:0]  best_n   [LANES];
    logic [DIST_W-1:0]  second_n [LANES];
    logic [IDX_W-1:0]   idx_n    [LANES];

    // Target lanes are folded in ascending order so that on equal distance
    // the earlier index keeps the best slot and the newcomer becomes second.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            best_n[i]   = best[i];
            second_n[i] = second[i];
            idx_n[i]    = best_idx[i];
        end
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (mask_p2[j]) begin
                    if (sad_p2[i][j] < best_n[i]) begin
                        second_n[i] = best_n[i];
                        best_n[i]   = sad_p2[i][j];
                        idx_n[i]    = base_p2 + IDX_W'(j);
                    end else if (sad_p2[i][j] < second_n[i]) begin
                        second_n[i] = sad_p2[i][j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                best[i]     <= '0;
                second[i]   <= '0;
                best_idx[i] <= '0;
            end
        end else if (trk_load) begin
            for (int i = 0; i < LANES; i++) begin
                best[i]     <= '1;
                second[i]   <= '1;
                best_idx[i] <= '0;
            end
        end else if (vld_p2) begin
            for (int i = 0; i < LANES; i++) begin
                best[i]     <= best_n[i];
                second[i]   <= second_n[i];
                best_idx[i] <= idx_n[i];
            end
        end
    end

    // Result fields come straight from the lane registers selected by
    // emit_k, which only moves on a handshake, so they hold under stall.
    assign res_valid   = res_valid_q;
    assign res_img_idx = res_valid_q ? IDX_W'(32'(grp) * 32'(LANES) + 32'(emit_k)) : '0;
    assign res_tar_idx = res_valid_q ? best_idx[emit_k] : '0;
    assign res_best    = res_valid_q ? best[emit_k] : '0;
    assign res_second  = res_valid_q ? second[emit_k] : '0;
    assign res_accept  = res_valid_q && ratio_pass(best[emit_k], second[emit_k]);

endmodule

// File: doc/sift_match_engine.md
Name: sift_match_engine

Overview:
- Parametrised successor to the 4-lane descriptor matcher in the SIFT matching stage.
- Loads a group of LANES image descriptors, then streams every target descriptor group from target memory. For each image descriptor it tracks the best and second-best sum-of-absolute-differences (SAD) distance.
- After the scan it applies a Lowe ratio test and emits one result per valid image keypoint on a ready/valid stream.
- It replaces the matched-memory read-modify-write scheme with per-lane result registers.

Parameters:
- LANES, 4, descriptors per group, applies to both image and target
- DESC_W, 384, bits per descriptor
- ELEM_W, 8, bits per unsigned descriptor element; DESC_W/ELEM_W elements per descriptor
- ADDR_W, 9, target group address width
- IDX_W, 11, keypoint index width
- DIST_W, 16, distance width; must be >= ELEM_W+clog2(DESC_W/ELEM_W)
- RATIO_NUM, 3, ratio-test numerator
- RATIO_SH, 2, ratio-test denominator is 2^RATIO_SH

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a match run; sampled only in IDLE
- img_kpt_num  in  IDX_W  number of image keypoints, latched on start
- tar_kpt_num  in  IDX_W  number of target keypoints, latched on start
- desc_req  out  1  request next image group; high throughout REQ
- desc_valid  in  1  img_desc is valid this cycle
- img_desc  in  LANES*DESC_W  image group; lane k at bits [k*DESC_W +: DESC_W]
- tar_rd_en  out  1  target memory read enable
- tar_addr  out  ADDR_W  target group address; data returns one cycle later
- tar_desc  in  LANES*DESC_W  target group read data
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_img_idx  out  IDX_W  image keypoint index
- res_tar_idx  out  IDX_W  index of best target keypoint
- res_best  out  DIST_W  best distance
- res_second  out  DIST_W  second-best distance
- res_accept  out  1  ratio test passed
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: state IDLE. All outputs 0. All internal registers, counters and the pipeline are cleared. Reset mid-run abandons the run with no result and no done.
- Group counts: img_grps = ceil(img_kpt_num/LANES); tar_grps = ceil(tar_kpt_num/LANES).
- Lane validity: image lane k of group g is valid iff g*LANES+k < img_kpt_num. Target lane j at address a is valid iff a*LANES+j < tar_kpt_num. Invalid target lanes never update trackers.
- IDLE:
  - start with both counts nonzero -> REQ; image group g = 0.
  - start with either count 0 -> DONE directly (done one cycle after start, no results).
  - start outside IDLE is ignored.
- REQ:
  - desc_req = 1; wait for desc_valid.
  - On desc_valid: capture img_desc into registers, set all best/second trackers to all-ones, then -> SCAN.
- SCAN:
  - tar_rd_en = 1 with tar_addr = 0..tar_grps-1, one address per cycle, no gaps.
  - Pipeline: stage 1 registers tar_desc plus its lane-valid mask; stage 2 registers LANES x LANES SAD values; stage 3 updates trackers.
  - After the last address is issued -> DRAIN.
- DRAIN:
  - Exactly 3 cycles with tar_rd_en = 0, until the last group has updated the trackers, then -> EMIT.
- Tracker update, per image lane, per cycle:
  - Consider the valid target lanes in ascending lane order.
  - d < best: second = best; best = d; best_idx = that target's index.
  - else d < second: second = d.
  - Ties never displace the existing best. The earlier address wins; within an address the lower lane wins.
  - Tie example: d equal to best also gives second = d (the else branch is not taken only on strict improvement of best).
- SAD arithmetic: sum over elements of |img_e - tar_e|, unsigned, computed at full width DIST_W with no saturation.
- Ratio test: res_accept = (best << RATIO_SH) < second*RATIO_NUM, evaluated at DIST_W+RATIO_SH+2 bits. If only one target is valid, second stays all-ones.
- EMIT:
  - Present valid image lanes in ascending k; res_img_idx = g*LANES+k.
  - Outputs are held stable while res_valid && !res_ready. Advance on handshake.
  - After the last valid lane: g+1 < img_grps -> REQ with g+1; otherwise -> DONE.
- DONE: done = 1 for one cycle -> IDLE; busy = 0 from the following cycle.

Test Plan:
- Exact match: img_kpt_num=4, tar_kpt_num=8. Target 5 equals image 2; all other targets differ by 10 on each of 48 elements (d=480). Expect res_img_idx=2: res_tar_idx=5, best=0, second=480, accept=1. Others: best=480, second=480, accept=0.
- Partial groups: img_kpt_num=5, tar_kpt_num=6. Expect 2 REQ handshakes, tar_addr 0,1 per group, exactly 5 results, no tracker update from target lanes 2-3 of address 1, done after the 5th handshake.
- Backpressure: hold res_ready=0 for 7 cycles during EMIT. res_valid stays 1 and all result fields stay constant; no result is lost or duplicated.
- Tie: targets 3 and 9 both at distance 100 from image 0, all others larger. Expect tar_idx=3, best=100, second=100, accept=0.
- Zero count: start with tar_kpt_num=0. Expect desc_req never asserted, done pulse one cycle after start, no res_valid.
- Reset mid-SCAN: assert rst_n=0 for one cycle. All outputs are 0 next cycle, state IDLE, and a subsequent start runs correctly.
